key_conditioner: RTL
====================

# key_conditioner

Parametrised front-end conditioner for the board push-keys; the next generation of the plain key one-shot. Each of N_KEYS raw key inputs is synchronised, debounced and turned into a stable pressed level plus single-cycle press, release and optional auto-repeat pulses. It sits between the raw key pins and the game/control logic, which consumes only the registered pulses.

## Interface

- N_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 16: consecutive cycles a new level must hold before it is accepted; must be at least 1.
- REPEAT_DELAY, 8: cycles from press_pulse to the first repeat_pulse; must be at least 1.
- REPEAT_RATE, 3: cycles between successive repeat_pulses; must be at least 1.
- ACTIVE_LOW, 1: 1 means a raw 0 is pressed, as on the board keys; 0 means a raw 1 is pressed.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- key_raw  input  N_KEYS  raw key pins, asynchronous to clk.
- repeat_en  input  1  synchronous to clk; enables auto-repeat on all channels.
- key_level  output  N_KEYS  debounced pressed state, 1 = pressed.
- press_pulse  output  N_KEYS  one-cycle pulse on each accepted press.
- release_pulse  output  N_KEYS  one-cycle pulse on each accepted release.
- repeat_pulse  output  N_KEYS  one-cycle auto-repeat pulse while held.

## Operation

- Channels are fully independent. Any number of them may pulse in the same cycle.
- Synchroniser: two flops per channel, reset to the unpressed raw value (1 when ACTIVE_LOW). Normalised p = synchroniser output, inverted when ACTIVE_LOW.
- Debounce, per channel: counter cnt, width $clog2(DEBOUNCE_CYCLES+1), reset 0.
  - p == key_level: cnt <= 0.
  - p != key_level and cnt == DEBOUNCE_CYCLES-1: commit. key_level <= p, cnt <= 0, and press_pulse or release_pulse <= 1 for exactly that one cycle.
  - Otherwise: cnt <= cnt+1.
- Any glitch shorter than DEBOUNCE_CYCLES at the synchroniser output produces no output change and clears cnt.
- Repeat FSM, per channel. Counter rc has width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE: on press commit with repeat_en=1, go to DELAY with rc <= 0.
  - DELAY: rc increments each cycle. When rc == REPEAT_DELAY-1, pulse repeat_pulse, set rc <= 0 and go to REPEAT.
  - REPEAT: rc increments each cycle. When rc == REPEAT_RATE-1, pulse repeat_pulse and set rc <= 0.
  - From DELAY or REPEAT, go to IDLE with rc <= 0 and no pulse when release commits or repeat_en=0.
  - Reasserting repeat_en while a key is held does not restart repeats; repeats resume only on the next press.
- repeat_pulse stays active during the release-debounce window, because key_level is still 1. It is forced to 0 in the release-commit cycle.
- All outputs are registered. Reset value of every output, counter and FSM state is 0/IDLE; synchroniser flops reset to the unpressed raw value.

## Timing

- Edge E0 is the first clk edge that samples a new raw level. key_level and the matching press or release pulse become visible after edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 edges latency. With the defaults this is 18 edges.
- Each pulse is high for exactly 1 cycle. press_pulse is coincident with the first cycle of key_level=1; release_pulse is coincident with the first cycle of key_level=0.
- With press_pulse in cycle T, repeat_pulse occurs at T+REPEAT_DELAY, then T+REPEAT_DELAY+k*REPEAT_RATE for k ≥ 1.
- rst_n low clears all outputs immediately; no pulse is emitted on reset entry or exit.
- If a key is held through reset, the press is re-detected DEBOUNCE_CYCLES+2 edges after rst_n deasserts.

## Test plan

All scenarios use N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3, ACTIVE_LOW=1.

- Clean press: key_raw=4'b1110 held from E0 -> press_pulse=4'b0001 for one cycle after E5, key_level[0]=1 from then on, all other outputs 0.
- Bounce: key_raw[1] low 3 cycles, high 1, low 2, high -> no outputs; then held low -> press_pulse[1] 6 edges after the final fall.
- Release: key 0 held, then key_raw[0] back to 1 -> release_pulse[0] one cycle, 6 edges later; key_level[0]=0 in the same cycle.
- Auto-repeat: repeat_en=1, hold key 2 with press_pulse[2] at T -> repeat_pulse[2] at T+8, T+11, T+14. Drop repeat_en at T+15 -> no further repeats. Re-raise repeat_en -> still none until re-press.
- Simultaneous: keys 0 and 3 fall on the same edge -> press_pulse=4'b1001 in a single cycle; later release_pulse=4'b1001 in a single cycle.
- Reset mid-hold: rst_n low while key 0 is held with repeats running -> all outputs 0 immediately. Release rst_n with key still held -> press_pulse[0] after 6 edges and no release_pulse.

Source files
------------

// File: rtl/key_conditioner.sv
// Key front end: per-channel 2-flop synchroniser, debounce counter and
// auto-repeat FSM producing a stable level plus registered single-cycle pulses.

module key_chan #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 3,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic repeat_en,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    logic           sync1, sync2, p;
    logic [CW-1:0]  cnt;
    logic           commit, press_commit, rel_commit;
    rep_state_t     state, state_nxt;
    logic [RCW-1:0] rc, rc_nxt;
    logic           rep_nxt;

    // Flops rest at the unpressed raw level so reset exit never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign p            = sync2 ^ ACTIVE_LOW;
    assign commit       = (p != key_level) && (cnt == CNT_LAST);
    assign press_commit = commit & p;
    assign rel_commit   = commit & ~p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= press_commit;
            release_pulse <= rel_commit;
            if (p == key_level) begin
                cnt <= '0;
            end else if (commit) begin
                key_level <= p;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Release commit wins over a due repeat, so the release cycle carries no repeat.
    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        rep_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (press_commit && repeat_en) begin
                    state_nxt = DELAY;
                    rc_nxt    = '0;
                end
            end
            DELAY: begin
                if (rel_commit || !repeat_en) begin
                    state_nxt = IDLE;
                    rc_nxt    = '0;
                end else if (rc == DELAY_LAST) begin
                    state_nxt = REPEAT;
                    rc_nxt    = '0;
                    rep_nxt   = 1'b1;
                end else begin
                    rc_nxt = rc + RCW'(1);
                end
            end
            REPEAT: begin
                if (rel_commit || !repeat_en) begin
                    state_nxt = IDLE;
                    rc_nxt    = '0;
                end else if (rc == RATE_LAST) begin
                    rc_nxt  = '0;
                    rep_nxt = 1'b1;
                end else begin
                    rc_nxt = rc + RCW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                rc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rc           <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            rc           <= rc_nxt;
            repeat_pulse <= rep_nxt;
        end
    end
endmodule

module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 3,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);
    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_raw      (key_raw[i]),
            .repeat_en    (repeat_en),
            .key_level    (key_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end
endmodule
